// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback bus of the scoreboarded register file.
//   master : decode/writeback side (drives addresses, writeback, issue info)
//   slave  : register file side (returns read data, stall, debug outputs)
// Read ports AD1/AD2 -> RD1/RD2, writeback WE3/AD3/WD3, issue_valid/use_rs1/
// use_rs2/issue_rd/flush -> stall, plus debug busy_count and a0.
interface reg_file_sb_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] AD1, AD2, AD3, issue_rd;
    logic [DATA_WIDTH-1:0]    RD1, RD2, WD3, a0;
    logic                     WE3, issue_valid, use_rs1, use_rs2, flush, stall;
    logic [ADDRESS_WIDTH:0]   busy_count;

    modport master (
        output AD1, AD2, AD3, WD3, WE3, issue_valid, use_rs1, use_rs2, issue_rd, flush,
        input  RD1, RD2, stall, busy_count, a0
    );

    modport slave (
        input  AD1, AD2, AD3, WD3, WE3, issue_valid, use_rs1, use_rs2, issue_rd, flush,
        output RD1, RD2, stall, busy_count, a0
    );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with per-register busy scoreboard and
// writeback-to-read bypass for the pipelined RV32I core.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - reg_file_sb_if.slave: two combinational read ports with bypass,
//          one writeback port, issue/flush inputs, combinational stall,
//          registered busy_count and registered a0 mirror.
module reg_file_sb #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int A0_INDEX      = 10
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);
    localparam int NREGS = 1 << ADDRESS_WIDTH;

    logic [NREGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NREGS-1:0]                 busy_q, busy_d;
    logic [ADDRESS_WIDTH:0]           busy_count_q, busy_count_d;
    logic [DATA_WIDTH-1:0]            a0_q, a0_d;

    logic wr_en;
    logic hit1, hit2, hit_rd;
    logic raw1, raw2, waw;
    logic stall_w, accept;

    // Writes to x0 are dropped, so x0 never stores data nor gets cleared/set.
    assign wr_en  = bus.WE3 && (bus.AD3 != '0);
    assign hit1   = wr_en && (bus.AD3 == bus.AD1);
    assign hit2   = wr_en && (bus.AD3 == bus.AD2);
    assign hit_rd = wr_en && (bus.AD3 == bus.issue_rd);

    // busy[0] is never set, so no explicit x0 term is needed in the hazards.
    assign raw1    = bus.use_rs1 && busy_q[bus.AD1] && !hit1;
    assign raw2    = bus.use_rs2 && busy_q[bus.AD2] && !hit2;
    assign waw     = (bus.issue_rd != '0) && busy_q[bus.issue_rd] && !hit_rd;
    assign stall_w = bus.issue_valid && (raw1 || raw2 || waw);
    assign accept  = bus.issue_valid && !stall_w && !bus.flush;

    always_comb begin
        bus.RD1 = '0;
        if (bus.AD1 != '0) bus.RD1 = hit1 ? bus.WD3 : regs_q[bus.AD1];
        bus.RD2 = '0;
        if (bus.AD2 != '0) bus.RD2 = hit2 ? bus.WD3 : regs_q[bus.AD2];
    end

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[bus.AD3] = bus.WD3;
            busy_d[bus.AD3] = 1'b0;
        end
        // Set after clear: a same-cycle reissue owns the register again.
        if (accept && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
        if (bus.flush) busy_d = '0;

        busy_count_d = '0;
        for (int i = 0; i < NREGS; i++)
            busy_count_d = busy_count_d + (ADDRESS_WIDTH+1)'(busy_d[i]);

        // Taken from next-state so a0 tracks the write on the same edge.
        a0_d = regs_d[A0_INDEX];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q       <= '0;
            busy_q       <= '0;
            busy_count_q <= '0;
            a0_q         <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            a0_q         <= a0_d;
        end
    end

    assign bus.stall      = stall_w;
    assign bus.busy_count = busy_count_q;
    assign bus.a0         = a0_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scenarios followed by random traffic, every cycle
// compared against an array-based model of the register file and scoreboard.
module tb_reg_file_sb;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_sb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    reg_file_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .A0_INDEX(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: register contents and set of in-flight destinations.
    logic [DW-1:0] m_regs [N];
    bit            m_busy [N];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit wb_to(input logic [AW-1:0] a);
        return bus.WE3 && (a != 0) && (bus.AD3 == a);
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wb_to(a)) return bus.WD3;
        return m_regs[int'(a)];
    endfunction

    // A register is usable if it is x0, idle, or being written back right now.
    function automatic bit m_ready(input logic [AW-1:0] a);
        return (a == 0) || !m_busy[int'(a)] || wb_to(a);
    endfunction

    function automatic bit m_stall();
        return bus.issue_valid && ((bus.use_rs1 && !m_ready(bus.AD1)) ||
                                   (bus.use_rs2 && !m_ready(bus.AD2)) ||
                                   !m_ready(bus.issue_rd));
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_rd1"},   bus.RD1, m_read(bus.AD1));
        chk({tag, "_rd2"},   bus.RD2, m_read(bus.AD2));
        chk({tag, "_stall"}, DW'(bus.stall), DW'(m_stall()));
        chk({tag, "_cnt"},   DW'(bus.busy_count), DW'(m_count()));
        chk({tag, "_a0"},    bus.a0, m_regs[10]);
    endtask

    task automatic idle();
        rst = 0;
        bus.AD1 = '0; bus.AD2 = '0; bus.AD3 = '0; bus.WD3 = '0; bus.WE3 = 0;
        bus.issue_valid = 0; bus.use_rs1 = 0; bus.use_rs2 = 0;
        bus.issue_rd = '0; bus.flush = 0;
    endtask

    // Advance one edge and apply the same edge to the model.
    task automatic tick();
        bit acc;
        acc = bus.issue_valid && !m_stall() && !bus.flush;
        @(posedge clk);
        if (rst) m_clear();
        else begin
            if (bus.WE3 && bus.AD3 != 0) begin
                m_regs[int'(bus.AD3)] = bus.WD3;
                m_busy[int'(bus.AD3)] = 1'b0;
            end
            if (acc && bus.issue_rd != 0) m_busy[int'(bus.issue_rd)] = 1'b1;
            if (bus.flush) for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        end
        #1;
    endtask

    initial begin
        m_clear();
        idle();
        rst = 1;
        bus.WE3 = 1; bus.AD3 = 5'd10; bus.WD3 = 32'hFFFF; bus.issue_valid = 1; bus.issue_rd = 5'd2;
        #2; tick();

        // Reset then read
        idle(); bus.AD1 = 5'd5; bus.issue_valid = 1; bus.use_rs1 = 1;
        #1;
        chk("rst_rd1", bus.RD1, 32'h0);
        chk("rst_rd2", bus.RD2, 32'h0);
        chk("rst_cnt", DW'(bus.busy_count), 32'h0);
        chk("rst_a0",  bus.a0, 32'h0);
        chk("rst_stall", DW'(bus.stall), 32'h0);
        tick();

        // Write with same-cycle bypass, then registered read
        idle(); bus.WE3 = 1; bus.AD3 = 5'd7; bus.WD3 = 32'hDEADBEEF; bus.AD1 = 5'd7;
        #1; chk("byp_rd1", bus.RD1, 32'hDEADBEEF); check_all("byp"); tick();
        bus.WE3 = 0;
        #1; chk("wr_rd1", bus.RD1, 32'hDEADBEEF); check_all("wr"); tick();

        // x0 protection
        idle(); bus.WE3 = 1; bus.AD3 = 5'd0; bus.WD3 = 32'h1234; tick();
        idle(); bus.AD1 = 5'd0; bus.issue_valid = 1; bus.issue_rd = 5'd0;
        #1; chk("x0_rd1", bus.RD1, 32'h0); tick();
        idle(); #1; chk("x0_cnt", DW'(bus.busy_count), 32'h0);

        // RAW stall held until writeback bypass releases it
        bus.issue_valid = 1; bus.issue_rd = 5'd3; tick();
        idle(); bus.issue_valid = 1; bus.use_rs1 = 1; bus.AD1 = 5'd3;
        #1; chk("raw_stall0", DW'(bus.stall), 32'h1); tick();
        #1; chk("raw_stall1", DW'(bus.stall), 32'h1); check_all("raw_hold"); tick();
        bus.WE3 = 1; bus.AD3 = 5'd3; bus.WD3 = 32'h55;
        #1; chk("raw_rel_stall", DW'(bus.stall), 32'h0); chk("raw_rel_rd1", bus.RD1, 32'h55); tick();
        idle(); #1; chk("raw_cnt", DW'(bus.busy_count), 32'h0);

        // Set/clear collision keeps busy, then WAW stall
        bus.issue_valid = 1; bus.issue_rd = 5'd4; tick();
        bus.WE3 = 1; bus.AD3 = 5'd4; bus.WD3 = 32'h44;
        #1; chk("col_stall", DW'(bus.stall), 32'h0); tick();
        bus.WE3 = 0;
        #1; chk("col_cnt", DW'(bus.busy_count), 32'h1); chk("waw_stall", DW'(bus.stall), 32'h1); tick();
        #1; chk("waw_cnt", DW'(bus.busy_count), 32'h1);

        // Flush together with a0 writeback
        idle(); bus.WE3 = 1; bus.AD3 = 5'd4; tick();
        idle(); bus.issue_valid = 1; bus.issue_rd = 5'd10; tick();
        bus.issue_rd = 5'd11; tick();
        idle(); #1; chk("fl_cnt2", DW'(bus.busy_count), 32'h2);
        bus.flush = 1; bus.WE3 = 1; bus.AD3 = 5'd10; bus.WD3 = 32'h99; bus.issue_valid = 1; bus.issue_rd = 5'd12;
        tick();
        idle(); bus.issue_valid = 1; bus.use_rs1 = 1; bus.AD1 = 5'd11;
        #1;
        chk("fl_cnt0", DW'(bus.busy_count), 32'h0);
        chk("fl_a0", bus.a0, 32'h99);
        chk("fl_stall", DW'(bus.stall), 32'h0);
        tick();

        // Reset mid-operation drops scoreboard and overrides a write
        idle(); bus.issue_valid = 1; bus.issue_rd = 5'd5; tick();
        idle(); rst = 1; bus.WE3 = 1; bus.AD3 = 5'd10; bus.WD3 = 32'h77; bus.issue_valid = 1; bus.issue_rd = 5'd6;
        tick();
        idle(); bus.issue_valid = 1; bus.use_rs1 = 1; bus.AD1 = 5'd5;
        #1;
        chk("mrst_cnt", DW'(bus.busy_count), 32'h0);
        chk("mrst_a0", bus.a0, 32'h0);
        chk("mrst_stall", DW'(bus.stall), 32'h0);
        tick();

        // Random traffic on a narrow address window to provoke hazards
        for (int c = 0; c < 600; c++) begin
            rst             = ($urandom_range(0, 99) == 0);
            bus.AD1         = AW'($urandom_range(0, 11));
            bus.AD2         = AW'($urandom_range(0, 11));
            bus.AD3         = AW'($urandom_range(0, 11));
            bus.WD3         = $urandom;
            bus.WE3         = ($urandom_range(0, 2) == 0);
            bus.issue_valid = ($urandom_range(0, 1) == 0);
            bus.use_rs1     = $urandom_range(0, 1) != 0;
            bus.use_rs2     = $urandom_range(0, 1) != 0;
            bus.issue_rd    = AW'($urandom_range(0, 11));
            bus.flush       = ($urandom_range(0, 24) == 0);
            #1;
            check_all("rnd");
            tick();
        end

        idle(); #1; check_all("end");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with a per-register busy scoreboard and write-to-read bypass, built as the successor of the single-cycle register file for the pipelined RV32I core. It sits between decode (read and issue) and writeback. It gives same-cycle forwarding of the writeback value, tracks destination registers of in-flight instructions, and raises a combinational stall for RAW and WAW hazards. It also exports a registered a0 and an occupancy count for the testbench and debug.

## Interface
Parameters:
- ADDRESS_WIDTH, 5, register index width; the file holds 2^ADDRESS_WIDTH registers.
- DATA_WIDTH, 32, register data width.
- A0_INDEX, 10, index mirrored on the a0 output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- AD1  input  ADDRESS_WIDTH  read address, port 1 (rs1).
- AD2  input  ADDRESS_WIDTH  read address, port 2 (rs2).
- RD1  output  DATA_WIDTH  read data, port 1 (combinational).
- RD2  output  DATA_WIDTH  read data, port 2 (combinational).
- WE3  input  1  writeback enable.
- AD3  input  ADDRESS_WIDTH  writeback address.
- WD3  input  DATA_WIDTH  writeback data.
- issue_valid  input  1  decode presents an instruction for issue this cycle.
- use_rs1  input  1  issuing instruction reads AD1.
- use_rs2  input  1  issuing instruction reads AD2.
- issue_rd  input  ADDRESS_WIDTH  destination of issuing instruction; 0 means no destination.
- flush  input  1  kill all in-flight instructions; clears the scoreboard.
- stall  output  1  issue blocked this cycle (combinational).
- busy_count  output  ADDRESS_WIDTH+1  number of set busy bits (registered).
- a0  output  DATA_WIDTH  registered copy of register A0_INDEX.

## Operation
- Storage: regs[0 .. 2^ADDRESS_WIDTH-1], busy[0 .. 2^ADDRESS_WIDTH-1]. Register 0 always reads 0, is never written and is never busy.
- Write: on a clock edge with WE3=1 and AD3!=0, regs[AD3] <= WD3. WE3 with AD3=0 is ignored.
- Read with bypass, for each port n: if ADn=0, RDn=0. Else if WE3=1 and AD3=ADn, RDn=WD3. Otherwise RDn=regs[ADn].
- A hazard on operand n requires all of the following: use_rsn=1, busy[ADn]=1, and no bypass hit on ADn this cycle.
- WAW hazard requires all of the following: issue_rd!=0, busy[issue_rd]=1, and no same-cycle writeback to issue_rd.
- stall = issue_valid and (RAW on port 1, or RAW on port 2, or WAW). stall is 0 when issue_valid=0.
- Issue accepted = issue_valid and not stall and not flush.
- Scoreboard set: an accepted issue with issue_rd!=0 sets busy[issue_rd].
- Scoreboard clear: WE3=1 with AD3!=0 clears busy[AD3].
- Same index set and cleared in one cycle: set wins, so busy stays 1. The new instruction owns the register.
- flush=1: all busy bits clear next edge and no issue is accepted that cycle. A writeback in the same cycle still updates regs.
- busy_count: next-state popcount of busy, registered.
- a0: registered copy of regs[A0_INDEX]. It is updated with the write value on the same edge as the write, so a0 equals the new value one cycle after WE3.

## Timing
- Reset (rst=1 at an edge): all regs = 0, all busy = 0, busy_count = 0, a0 = 0. The outputs after that edge are RD1=RD2=0 (absent bypass) and stall=0.
- Reset overrides write, issue and flush in the same cycle.
- Reset mid-operation discards all pending scoreboard state.
- Read latency is 0 cycles (combinational), including the bypass path.
- A register is visible through regs one edge after its write.
- stall is valid in the same cycle as its inputs and depends on current busy plus the current writeback. There is no registered stall.
- Issue-to-busy is 1 edge. Writeback-to-not-busy is 1 edge, but the operand is already unstalled in the writeback cycle via bypass.
- Maximum busy_count is 2^ADDRESS_WIDTH-1, so the ADDRESS_WIDTH+1 width never wraps.

## Test plan
- Reset then read: assert rst for 1 cycle, then AD1=5, AD2=0 -> RD1=0, RD2=0, busy_count=0, a0=0, stall=0.
- Write and bypass: WE3=1, AD3=7, WD3=0xDEADBEEF with AD1=7 in the same cycle -> RD1=0xDEADBEEF that cycle. The next cycle, with WE3=0, gives RD1=0xDEADBEEF.
- x0 protection: WE3=1, AD3=0, WD3=0x1234 -> next cycle AD1=0 reads 0. Issue with issue_rd=0 -> busy_count stays 0.
- RAW stall: issue rd=3, then the next cycle issue_valid with use_rs1=1, AD1=3 -> stall=1. Hold until a cycle with WE3=1, AD3=3, WD3=0x55 -> stall=0 and RD1=0x55 in that cycle. busy_count returns to 0.
- Set/clear collision and WAW: busy[4]=1. The same cycle has WE3 to 4 and an accepted issue with rd=4 -> busy[4] remains 1 and busy_count is unchanged. A further issue with rd=4 without writeback -> stall=1.
- Flush and a0: issue rd=10 and rd=11, busy_count=2. Assert flush together with WE3=1, AD3=10, WD3=0x99 -> next cycle busy_count=0 and a0=0x99. Issues with use_rs1=1, AD1=11 -> stall=0.
